lut_routethru_pipe: RTL

Parametrised multi-channel flip-flop pipeline for place-and-route feature tests: WIDTH independent input channels pass through DEPTH register stages to WIDTH outputs. The design exercises FF packing and LUT route-thru in architectures that have no direct FF input mux. It also provides a scan mode that links every register into one serial chain, and a fill counter that flags when the pipeline holds only freshly captured data. It sits as a test top between input and output buffer cells.

---
 rtl/lut_routethru_pipe.sv | 85 ++++++++
 1 files changed

// File: rtl/lut_routethru_pipe.sv
// lut_routethru_pipe
// WIDTH parallel channels through DEPTH register stages, with a scan mode
// that strings every register into one serial chain and a saturating fill
// counter that raises valid once the pipe holds only parallel-mode data.
//
// Optional build macro: LUT_ROUTETHRU_PIPE_INV_EN adds the inv port, which
// conditionally inverts the parallel input ahead of stage 0 so a real LUT
// sits in front of the first FF instead of a route-thru.
//
// Register layout: stage s, bit b lives at chain[s*WIDTH + b]. This makes the
// parallel shift and the scan shift the same flat vector shifted by WIDTH or
// by 1, so switching modes never rearranges or loses contents.

module lut_routethru_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  input  logic             en,
  input  logic             mode,
  input  logic             scan_in,
`ifdef LUT_ROUTETHRU_PIPE_INV_EN
  input  logic             inv,
`endif
  output logic [WIDTH-1:0] o,
  output logic             scan_out,
  output logic             valid
);

  localparam int NBITS = WIDTH * DEPTH;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [NBITS-1:0] chain;
  logic [NBITS-1:0] chain_nxt;
  logic [WIDTH-1:0] d0;
  logic [CW-1:0]    cnt;

  // Stage-0 data: plain route-thru, or an inverting LUT when the option is built in
  always_comb begin
`ifdef LUT_ROUTETHRU_PIPE_INV_EN
    d0 = inv ? ~i : i;
`else
    d0 = i;
`endif
  end

  // Next chain value: whole-word shift in parallel mode, single-bit shift in scan mode
  always_comb begin
    chain_nxt = chain;
    if (mode) begin
      chain_nxt = (chain << 1) | NBITS'(scan_in);
    end else begin
      chain_nxt = (chain << WIDTH) | NBITS'(d0);
    end
  end

  // Data registers advance only when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (en) begin
      chain <= chain_nxt;
    end
  end

  // Fill counter: any scan-mode edge discards the fill, enabled parallel edges count up to DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (mode) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_FULL)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o        = chain[NBITS-1 -: WIDTH];
  assign scan_out = chain[NBITS-1];
  // valid drops the moment mode goes high, without waiting for an edge
  assign valid    = (cnt == CNT_FULL) && !mode;

endmodule
